// File: rtl/csr_file_m.sv
// Machine-mode CSR file for the RV32I core: read/write/set/clear, trap entry and mret, interrupt pending/priority.
// Define CSR_COUNTERS_EN to build the 64-bit mcycle/minstret counters; otherwise those addresses are unmapped.
module csr_file_m #(
  parameter int          NUM_IRQ     = 6,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wd,
  output logic [31:0]        csr_rd,
  output logic               csr_illegal,
  input  logic [NUM_IRQ-1:0] irq_pending,
  output logic               irq_take,
  output logic [4:0]         irq_id,
  input  logic               trap_req,
  input  logic [31:0]        trap_cause,
  input  logic [31:0]        trap_pc,
  input  logic               mret,
  input  logic               instr_retire,
  output logic [31:0]        trap_target,
  output logic [31:0]        mepc_out
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  logic               mstat_mie_q, mstat_mie_d;
  logic               mstat_mpie_q, mstat_mpie_d;
  logic [NUM_IRQ-1:0] mie_q, mie_d;
  logic [31:0]        mtvec_q, mtvec_d;
  logic [31:0]        mscratch_q, mscratch_d;
  logic [31:0]        mepc_q, mepc_d;
  logic [31:0]        mcause_q, mcause_d;

  logic               op_act, op_wr, mapped, wr_en;
  logic [31:0]        old_val, new_val;
  logic [NUM_IRQ-1:0] irq_en;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`endif

  function automatic logic [31:0] csr_apply(input logic [2:0] op, input logic [31:0] old,
                                            input logic [31:0] wd);
    case (op)
      3'd2:    return wd;
      3'd3:    return old | wd;
      3'd4:    return old & ~wd;
      default: return old;
    endcase
  endfunction

  assign op_act = (csr_op >= 3'd1) && (csr_op <= 3'd4);
  assign op_wr  = (csr_op >= 3'd2) && (csr_op <= 3'd4);

  always_comb begin
    mapped  = 1'b1;
    old_val = 32'h0;
    case (csr_addr)
      A_MSTATUS:   old_val = {24'h0, mstat_mpie_q, 3'b000, mstat_mie_q, 3'b000};
      A_MIE:       old_val = 32'(mie_q);
      A_MTVEC:     old_val = mtvec_q;
      A_MSCRATCH:  old_val = mscratch_q;
      A_MEPC:      old_val = mepc_q;
      A_MCAUSE:    old_val = mcause_q;
      A_MIP:       old_val = 32'(irq_pending);
`ifdef CSR_COUNTERS_EN
      A_MCYCLE:    old_val = mcycle_q[31:0];
      A_MCYCLEH:   old_val = mcycle_q[63:32];
      A_MINSTRET:  old_val = minstret_q[31:0];
      A_MINSTRETH: old_val = minstret_q[63:32];
`endif
      default:     mapped = 1'b0;
    endcase
  end

  assign new_val     = csr_apply(csr_op, old_val, csr_wd);
  assign csr_rd      = (op_act && mapped) ? old_val : 32'h0;
  assign csr_illegal = op_act && (!mapped || (op_wr && (csr_addr == A_MIP)));
  // Trap entry and mret own the cycle; a concurrent CSR write is dropped.
  assign wr_en       = op_wr && !csr_illegal && !trap_req && !mret;

  always_comb begin
    mstat_mie_d  = mstat_mie_q;
    mstat_mpie_d = mstat_mpie_q;
    mie_d        = mie_q;
    mtvec_d      = mtvec_q;
    mscratch_d   = mscratch_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    if (trap_req) begin
      mepc_d       = {trap_pc[31:2], 2'b00};
      mcause_d     = trap_cause;
      mstat_mpie_d = mstat_mie_q;
      mstat_mie_d  = 1'b0;
    end else if (mret) begin
      mstat_mie_d  = mstat_mpie_q;
      mstat_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        A_MSTATUS: begin
          mstat_mie_d  = new_val[3];
          mstat_mpie_d = new_val[7];
        end
        A_MIE:      mie_d      = new_val[NUM_IRQ-1:0];
        A_MTVEC:    mtvec_d    = {new_val[31:2], 1'b0, new_val[0]};
        A_MSCRATCH: mscratch_d = new_val;
        A_MEPC:     mepc_d     = {new_val[31:2], 2'b00};
        A_MCAUSE:   mcause_d   = new_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstat_mie_q  <= 1'b0;
      mstat_mpie_q <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RESET;
      mscratch_q   <= 32'h0;
      mepc_q       <= 32'h0;
      mcause_q     <= 32'h0;
    end else begin
      mstat_mie_q  <= mstat_mie_d;
      mstat_mpie_q <= mstat_mpie_d;
      mie_q        <= mie_d;
      mtvec_q      <= mtvec_d;
      mscratch_q   <= mscratch_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  // A write to one half replaces it and holds the other half, skipping that cycle's increment.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'h0, instr_retire};
    if (wr_en) begin
      case (csr_addr)
        A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], new_val};
        A_MCYCLEH:   mcycle_d   = {new_val, mcycle_q[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[63:32], new_val};
        A_MINSTRETH: minstret_d = {new_val, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  logic unused_instr_retire;
  assign unused_instr_retire = instr_retire;
`endif

  assign irq_en   = irq_pending & mie_q;
  assign irq_take = mstat_mie_q & (|irq_en);

  always_comb begin
    irq_id = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_en[i]) irq_id = 5'(i);
    end
  end

  always_comb begin
    trap_target = {mtvec_q[31:2], 2'b00};
    if (mtvec_q[0] && trap_cause[31])
      trap_target = {mtvec_q[31:2], 2'b00} + {25'h0, trap_cause[4:0], 2'b00};
  end

  assign mepc_out = mepc_q;

endmodule

// File: tb/tb_csr_file_m.sv
// Scoreboard bench for csr_file_m: directed stimulus queues expected outputs, a negedge monitor compares them.
module tb_csr_file_m;

  localparam int          NIRQ  = 6;
  localparam logic [31:0] MTVRST = 32'h0000_1001;

  localparam int K_RD = 0, K_ILL = 1, K_TAKE = 2, K_ID = 3, K_TGT = 4, K_MEPC = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [31:0]     csr_wd;
  logic [31:0]     csr_rd;
  logic            csr_illegal;
  logic [NIRQ-1:0] irq_pending;
  logic            irq_take;
  logic [4:0]      irq_id;
  logic            trap_req;
  logic [31:0]     trap_cause;
  logic [31:0]     trap_pc;
  logic            mret;
  logic            instr_retire;
  logic [31:0]     trap_target;
  logic [31:0]     mepc_out;

  csr_file_m #(.NUM_IRQ(NIRQ), .MTVEC_RESET(MTVRST)) dut (
    .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wd(csr_wd),
    .csr_rd(csr_rd), .csr_illegal(csr_illegal), .irq_pending(irq_pending),
    .irq_take(irq_take), .irq_id(irq_id), .trap_req(trap_req), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .mret(mret), .instr_retire(instr_retire),
    .trap_target(trap_target), .mepc_out(mepc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_RD:    return csr_rd;
      K_ILL:   return {31'h0, csr_illegal};
      K_TAKE:  return {31'h0, irq_take};
      K_ID:    return {27'h0, irq_id};
      K_TGT:   return trap_target;
      default: return mepc_out;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      a = actual(e.kind);
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
      end
    end
  end

  task automatic expect_v(input int k, input logic [31:0] v, input string n);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One CSR access cycle: checks pre-write read data and the fault flag.
  task automatic acc(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_ill, input string n);
    csr_op   = op;
    csr_addr = a;
    csr_wd   = wd;
    expect_v(K_RD, exp_rd, {n, "_rd"});
    expect_v(K_ILL, {31'h0, exp_ill}, {n, "_ill"});
    step();
    csr_op = 3'd0;
  endtask

  task automatic wr_only(input logic [11:0] a, input logic [31:0] wd, input string n);
    csr_op   = 3'd2;
    csr_addr = a;
    csr_wd   = wd;
    expect_v(K_ILL, 32'h0, {n, "_ill"});
    step();
    csr_op = 3'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; csr_op = 3'd2; csr_addr = 12'h340; csr_wd = 32'hAA;
    irq_pending = '0; trap_req = 1'b0; trap_cause = 32'h0; trap_pc = 32'h0;
    mret = 1'b0; instr_retire = 1'b0;
    step(); step();
    rst = 1'b0; csr_op = 3'd0;

    // Reset values
    expect_v(K_TAKE, 32'h0, "rst_take");
    expect_v(K_TGT, 32'h1000, "rst_tgt");
    acc(3'd1, 12'h300, 0, 32'h0, 1'b0, "rst_mstatus");
    acc(3'd1, 12'h304, 0, 32'h0, 1'b0, "rst_mie");
    acc(3'd1, 12'h305, 0, MTVRST, 1'b0, "rst_mtvec");
    acc(3'd1, 12'h340, 0, 32'h0, 1'b0, "rst_mscratch");
    acc(3'd1, 12'h341, 0, 32'h0, 1'b0, "rst_mepc");
    acc(3'd1, 12'h342, 0, 32'h0, 1'b0, "rst_mcause");
    acc(3'd1, 12'h344, 0, 32'h0, 1'b0, "rst_mip");

    // Interrupt enable, pending and priority
    acc(3'd2, 12'h304, 32'hFFFF_FFFF, 32'h0, 1'b0, "mie_wr");
    acc(3'd1, 12'h304, 0, 32'h3F, 1'b0, "mie_mask");
    acc(3'd3, 12'h300, 32'h8, 32'h0, 1'b0, "mstatus_set");
    irq_pending = 6'b001100;
    expect_v(K_TAKE, 32'h1, "irq_take_a");
    expect_v(K_ID, 32'd2, "irq_id_a");
    acc(3'd1, 12'h300, 0, 32'h8, 1'b0, "mstatus_rd");
    irq_pending = 6'b100000;
    expect_v(K_TAKE, 32'h1, "irq_take_b");
    expect_v(K_ID, 32'd5, "irq_id_b");
    acc(3'd1, 12'h344, 0, 32'h20, 1'b0, "mip_rd");
    irq_pending = '0;
    expect_v(K_TAKE, 32'h0, "irq_take_none");
    expect_v(K_ID, 32'd0, "irq_id_none");
    step();

    // Read-modify-write ops on mscratch
    acc(3'd2, 12'h340, 32'hF0F0, 32'h0, 1'b0, "scr_wr");
    acc(3'd3, 12'h340, 32'h000F, 32'hF0F0, 1'b0, "scr_set");
    acc(3'd4, 12'h340, 32'h00F0, 32'hF0FF, 1'b0, "scr_clr");
    acc(3'd1, 12'h340, 0, 32'hF00F, 1'b0, "scr_rd");

    // mtvec bit1 masked; vectored trap entry with concurrent write suppressed
    acc(3'd2, 12'h305, 32'h203, MTVRST, 1'b0, "mtvec_wr");
    acc(3'd1, 12'h305, 0, 32'h201, 1'b0, "mtvec_rd");
    trap_req = 1'b1; trap_pc = 32'h103; trap_cause = 32'h8000_0003;
    expect_v(K_TGT, 32'h20C, "trap_tgt_vec");
    acc(3'd2, 12'h340, 32'h55, 32'hF00F, 1'b0, "trap_wr");
    trap_req = 1'b0;
    expect_v(K_MEPC, 32'h100, "mepc_out");
    acc(3'd1, 12'h341, 0, 32'h100, 1'b0, "mepc_rd");
    acc(3'd1, 12'h300, 0, 32'h80, 1'b0, "trap_mstatus");
    acc(3'd1, 12'h342, 0, 32'h8000_0003, 1'b0, "mcause_rd");
    acc(3'd1, 12'h340, 0, 32'hF00F, 1'b0, "scr_after_trap");
    trap_cause = 32'h2;
    irq_pending = 6'b000001;
    expect_v(K_TGT, 32'h200, "trap_tgt_direct");
    expect_v(K_TAKE, 32'h0, "take_mie_off");
    step();
    mret = 1'b1;
    acc(3'd2, 12'h340, 32'h77, 32'hF00F, 1'b0, "mret_wr");
    mret = 1'b0;
    expect_v(K_TAKE, 32'h1, "take_after_mret");
    expect_v(K_ID, 32'd0, "id_after_mret");
    acc(3'd1, 12'h300, 0, 32'h88, 1'b0, "mret_mstatus");
    acc(3'd1, 12'h340, 0, 32'hF00F, 1'b0, "scr_after_mret");

    // Illegal and no-op accesses
    acc(3'd2, 12'h344, 32'hFF, 32'h1, 1'b1, "mip_wr");
    acc(3'd3, 12'h7FF, 32'hFF, 32'h0, 1'b1, "unmapped");
    acc(3'd0, 12'h340, 32'h1, 32'h0, 1'b0, "op_none");
    acc(3'd5, 12'h340, 32'h1, 32'h0, 1'b0, "op_five");
    acc(3'd1, 12'h344, 0, 32'h1, 1'b0, "mip_after");
    acc(3'd1, 12'h340, 0, 32'hF00F, 1'b0, "scr_after_ill");

`ifdef CSR_COUNTERS_EN
    wr_only(12'hB00, 32'hFFFF_FFFF, "mcycle_wr");
    wr_only(12'hB80, 32'hFFFF_FFFF, "mcycleh_wr");
    acc(3'd1, 12'hB00, 0, 32'hFFFF_FFFF, 1'b0, "mcycle_max");
    acc(3'd1, 12'hB80, 0, 32'h0, 1'b0, "mcycleh_wrap");
    acc(3'd1, 12'hB00, 0, 32'h1, 1'b0, "mcycle_after");
    acc(3'd1, 12'hB02, 0, 32'h0, 1'b0, "minstret_idle");
    instr_retire = 1'b1;
    acc(3'd1, 12'hB02, 0, 32'h0, 1'b0, "minstret_0");
    acc(3'd1, 12'hB02, 0, 32'h1, 1'b0, "minstret_1");
    acc(3'd1, 12'hB02, 0, 32'h2, 1'b0, "minstret_2");
    wr_only(12'hB02, 32'h5, "minstret_wr");
    instr_retire = 1'b0;
    acc(3'd1, 12'hB02, 0, 32'h5, 1'b0, "minstret_held");
    acc(3'd1, 12'hB82, 0, 32'h0, 1'b0, "minstreth");
`else
    acc(3'd1, 12'hB00, 0, 32'h0, 1'b1, "mcycle_off");
    acc(3'd2, 12'hB82, 32'h1, 32'h0, 1'b1, "minstreth_off");
`endif

    // Reset during a trap and a write discards both
    rst = 1'b1; trap_req = 1'b1; trap_pc = 32'h444; csr_op = 3'd2; csr_addr = 12'h340;
    csr_wd = 32'h1234;
    step();
    rst = 1'b0; trap_req = 1'b0; csr_op = 3'd0;
    expect_v(K_TAKE, 32'h0, "rst2_take");
    expect_v(K_MEPC, 32'h0, "rst2_mepc");
    acc(3'd1, 12'h340, 0, 32'h0, 1'b0, "rst2_scr");
    acc(3'd1, 12'h305, 0, MTVRST, 1'b0, "rst2_mtvec");
    acc(3'd1, 12'h300, 0, 32'h0, 1'b0, "rst2_mstatus");

    step();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_file_m.md
# csr_file_m

Parametrised machine-mode Control and Status Register file for the RV32I core, and the successor to the fixed 6-bit-mask CSR block. It implements CSR read, write, set and clear with illegal-access detection. It also provides mstatus MIE/MPIE save and restore on trap entry and `mret`, a configurable interrupt-mask width with pending and priority logic, vectored or direct `mtvec`, and optional 64-bit cycle and instret counters. It sits between the main decoder, the interrupt controller and the PC-select logic.

## Interface
Parameters:
- NUM_IRQ, 6: number of interrupt lines (1..32); width of mie/mip.
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- csr_op  in  3  0=none, 1=read, 2=write, 3=set, 4=clear; 5..7 behave as none.
- csr_addr  in  12  CSR address.
- csr_wd  in  32  write/set/clear operand (rs1 or zimm).
- csr_rd  out  32  read data, combinational.
- csr_illegal  out  1  access fault, combinational.
- irq_pending  in  NUM_IRQ  level interrupt lines.
- irq_take  out  1  interrupt should be taken.
- irq_id  out  5  lowest-index pending and enabled line.
- trap_req  in  1  trap entry this cycle.
- trap_cause  in  32  mcause value for trap.
- trap_pc  in  32  PC saved to mepc.
- mret  in  1  return from trap.
- instr_retire  in  1  one instruction retired.
- trap_target  out  32  handler address.
- mepc_out  out  32  return address for mret.

## Operation
- Address map:
  - mstatus 0x300: bit3 MIE, bit7 MPIE, others read 0.
  - mie 0x304.
  - mtvec 0x305: bit0 is mode; bit1 reads 0.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342.
  - mip 0x344: read-only, equals irq_pending.
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
- New value per op:
  - write: wd.
  - set: old | wd.
  - clear: old & ~wd.
  - Then apply the field mask. mie bits above NUM_IRQ-1 always read 0.
- csr_rd returns the pre-write value of the addressed CSR. It returns 0 when csr_op=0 or the address is unmapped.
- csr_illegal=1 when csr_op is 1..4 and either:
  - the address is unmapped, or
  - csr_op is 2..4 on mip.
  - No state changes on an illegal access.
- irq_take = MIE & |(irq_pending & mie). irq_id is the lowest set index of (irq_pending & mie), or 0 if none.
- trap_target:
  - If mtvec.mode=1 and trap_cause[31]=1: {mtvec[31:2],2'b00} + 4*trap_cause[4:0], mod 2^32.
  - Otherwise: {mtvec[31:2],2'b00}.
- Trap entry (trap_req=1):
  - mepc <= trap_pc & ~3.
  - mcause <= trap_cause.
  - MPIE <= MIE, MIE <= 0.
- mret (trap_req=0): MIE <= MPIE, MPIE <= 1.
- Priority in one cycle:
  - trap_req beats mret.
  - Either one suppresses any CSR write that cycle; csr_rd is still valid.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when instr_retire=1.
  - Both are 64-bit and wrap from 2^64-1 to 0.
  - A CSR write to either half replaces that half and suppresses that counter's increment for that cycle; the other half is unchanged.

## Timing
- Reads, csr_illegal, irq_take, irq_id and trap_target are combinational, with zero latency.
- CSR writes, trap entry, mret and counter updates are visible on the cycle after the edge.
- rst has priority over all inputs.
- Reset values:
  - mstatus=0, mie=0, mtvec=MTVEC_RESET, mscratch=0, mepc=0, mcause=0, all counters 0.
  - Hence irq_take=0 out of reset.
- rst asserted mid-trap or mid-write discards the operation.
- irq_pending is sampled only combinationally; no internal latching.

## Configuration
- CSR_COUNTERS_EN defined: mcycle/mcycleh/minstret/minstreth are implemented as above.
- CSR_COUNTERS_EN undefined:
  - Counter addresses are unmapped: csr_rd=0 and csr_illegal=1.
  - instr_retire is ignored.
  - No counter flops are synthesised.

## Test plan
- Reset, then read each CSR -> mtvec=MTVEC_RESET, all others 0, irq_take=0.
- Write mie=0xFFFF_FFFF with NUM_IRQ=6, then set mstatus=0x8 and irq_pending=6'b001100 -> mie reads 0x3F, irq_take=1, irq_id=2.
- Write mscratch=0xF0F0, set 0x000F, clear 0x00F0 -> reads 0xF0F0, 0xF0FF, 0xF00F across successive cycles.
- MIE=1, then trap_req with trap_pc=0x103, trap_cause=0x8000_0003 and mtvec=0x201 -> trap_target=0x20C; next cycle mepc=0x100, MIE=0, MPIE=1. Then mret -> MIE=1, MPIE=1.
- trap_req together with a CSR write of mscratch=0x55 -> mscratch unchanged. Write to mip or to 0x7FF -> csr_illegal=1, no state change.
- Counters enabled, write mcycle=0xFFFF_FFFF with mcycleh=0xFFFF_FFFF -> wraps to 0 after the next cycle. Counters disabled -> read of 0xB00 gives 0 and csr_illegal=1.
